// File: rtl/imem_fetch_port.sv
// imem_fetch_port: instruction-memory responder for the PC address bus.
// It accepts a byte address, then returns the instruction word after
// WAIT_STATES extra cycles through a ready/valid handshake. Misaligned or
// out-of-range fetches return a fault with a NOP word. A flush drops the
// in-flight fetch, and a write port loads the program image.
module imem_fetch_port #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic          im_clk,
    input  logic          im_rst_n,
    input  logic          im_req,
    input  logic [31:0]   im_addr,
    output logic          im_ready,
    output logic          im_valid,
    output logic [31:0]   im_instr,
    output logic          im_fault,
    input  logic          im_flush,
    input  logic          im_wr_en,
    input  logic [AW-1:0] im_wr_addr,
    input  logic [31:0]   im_wr_data
);

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [30:0] DEPTH_W = 31'(DEPTH);
    localparam logic [3:0]  WS_LOAD = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Program image storage; deliberately left without a reset.
    logic [31:0] mem [DEPTH];

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          valid_q, valid_d;
    logic [31:0]   instr_q, instr_d;
    logic          fault_q, fault_d;

    logic          accept;
    logic          req_fault;
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_word;

    // Handshake and fault classification of the address being presented now.
    always_comb begin
        im_ready  = ((state_q == IDLE) || (state_q == RESP)) && !im_flush;
        accept    = im_req && im_ready;
        req_fault = (im_addr[1:0] != 2'b00) || ({1'b0, im_addr[31:2]} >= DEPTH_W);
    end

    // Memory read port: the latched word while waiting, else the live address.
    always_comb begin
        rd_idx  = (state_q == WAIT) ? addr_q : im_addr[AW+1:2];
        rd_word = mem[rd_idx];
    end

    // Program-load write port, active in every state.
    always_ff @(posedge im_clk) begin
        if (im_wr_en) begin
            mem[im_wr_addr] <= im_wr_data;
        end
    end

    // Next-state and response logic; flush overrides everything else.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        valid_d = 1'b0;
        instr_d = instr_q;
        fault_d = fault_q;

        if (im_flush) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else begin
            unique case (state_q)
                IDLE, RESP: begin
                    if (accept) begin
                        addr_d = im_addr[AW+1:2];
                        if (req_fault || (WAIT_STATES == 0)) begin
                            state_d = RESP;
                            valid_d = 1'b1;
                            instr_d = req_fault ? NOP : rd_word;
                            fault_d = req_fault;
                        end else begin
                            state_d = WAIT;
                            cnt_d   = WS_LOAD;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        state_d = RESP;
                        valid_d = 1'b1;
                        instr_d = rd_word;
                        fault_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // State and response registers with asynchronous active-low reset.
    always_ff @(posedge im_clk or negedge im_rst_n) begin
        if (!im_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            instr_q <= NOP;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
        end
    end

    assign im_valid = valid_q;
    assign im_instr = instr_q;
    assign im_fault = fault_q;

endmodule

// File: tb/tb_imem_fetch_port.sv
// Scoreboard bench for imem_fetch_port: three instances with WAIT_STATES
// 0, 2 and 3 share the clock, reset and write port.
module tb_imem_fetch_port;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        int          inst;
        logic [31:0] instr;
        logic        fault;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req   [3];
    logic [31:0] addr  [3];
    logic        flush [3];
    logic        ready [3];
    logic        valid [3];
    logic [31:0] instr [3];
    logic        fault [3];
    logic        wr_en = 1'b0;
    logic [7:0]  wr_addr = 8'd0;
    logic [31:0] wr_data = 32'd0;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          busy  [3];
    int          ws_of [3];
    logic [31:0] mem_model [256];
    exp_t        sb [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    imem_fetch_port #(.DEPTH(256), .WAIT_STATES(0)) dut0 (
        .im_clk(clk), .im_rst_n(rst_n), .im_req(req[0]), .im_addr(addr[0]),
        .im_ready(ready[0]), .im_valid(valid[0]), .im_instr(instr[0]), .im_fault(fault[0]),
        .im_flush(flush[0]), .im_wr_en(wr_en), .im_wr_addr(wr_addr), .im_wr_data(wr_data));

    imem_fetch_port #(.DEPTH(256), .WAIT_STATES(2)) dut1 (
        .im_clk(clk), .im_rst_n(rst_n), .im_req(req[1]), .im_addr(addr[1]),
        .im_ready(ready[1]), .im_valid(valid[1]), .im_instr(instr[1]), .im_fault(fault[1]),
        .im_flush(flush[1]), .im_wr_en(wr_en), .im_wr_addr(wr_addr), .im_wr_data(wr_data));

    imem_fetch_port #(.DEPTH(256), .WAIT_STATES(3)) dut2 (
        .im_clk(clk), .im_rst_n(rst_n), .im_req(req[2]), .im_addr(addr[2]),
        .im_ready(ready[2]), .im_valid(valid[2]), .im_instr(instr[2]), .im_fault(fault[2]),
        .im_flush(flush[2]), .im_wr_en(wr_en), .im_wr_addr(wr_addr), .im_wr_data(wr_data));

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // One negedge-to-negedge cycle on instance k, with the bench model of
    // readiness and expected responses kept in step.
    task automatic applyStimulus(input int k, input logic do_req, input logic [31:0] a,
                                 input logic do_flush, input logic do_wr,
                                 input logic [7:0] wa, input logic [31:0] wd);
        logic exp_rdy;
        logic flt;
        exp_t e;
        req[k]   = do_req;
        addr[k]  = a;
        flush[k] = do_flush;
        wr_en    = do_wr;
        wr_addr  = wa;
        wr_data  = wd;
        #1;
        exp_rdy = (busy[k] == 0) && !do_flush;
        checkOutput("ready", {31'd0, ready[k]}, {31'd0, exp_rdy});
        if (do_flush) begin
            if (sb.size() > 0 && sb[$].inst == k && sb[$].due > cyc) void'(sb.pop_back());
            busy[k] = 0;
        end else if (do_req && exp_rdy) begin
            flt     = (a[1:0] != 2'b00) || (a[31:2] >= 30'd256);
            e.inst  = k;
            e.fault = flt;
            e.instr = flt ? NOP : mem_model[a[9:2]];
            e.due   = cyc + (flt ? 1 : ws_of[k] + 1);
            sb.push_back(e);
            busy[k] = flt ? 0 : ws_of[k];
        end else if (busy[k] > 0) begin
            busy[k]--;
        end
        if (do_wr) mem_model[wa] = wd;
        @(negedge clk);
    endtask

    task automatic idle(input int k, input int n);
        for (int i = 0; i < n; i++) applyStimulus(k, 1'b0, 32'h0000_000C, 1'b0, 1'b0, 8'd0, 32'd0);
    endtask

    task automatic fetch(input int k, input logic [31:0] a);
        applyStimulus(k, 1'b1, a, 1'b0, 1'b0, 8'd0, 32'd0);
    endtask

    // Response monitor: every valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                if (valid[k]) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_valid", k, 32'hFFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        checkOutput("resp_inst", k, e.inst);
                        checkOutput("resp_instr", instr[k], e.instr);
                        checkOutput("resp_fault", {31'd0, fault[k]}, {31'd0, e.fault});
                        checkOutput("resp_latency", cyc, e.due);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int vcount;
        ws_of[0] = 0; ws_of[1] = 2; ws_of[2] = 3;
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b0; addr[k] = 32'd0; flush[k] = 1'b0; busy[k] = 0;
        end

        // Reset values while reset is held.
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput("rst_valid", {31'd0, valid[k]}, 32'd0);
            checkOutput("rst_fault", {31'd0, fault[k]}, 32'd0);
            checkOutput("rst_instr", instr[k], NOP);
            checkOutput("rst_ready", {31'd0, ready[k]}, 32'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Preload program image words 0..3.
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 1'b0, 32'd0, 1'b0, 1'b1, 8'(i), 32'h1111_1111 * (i + 1));

        // Zero wait states: single fetch, then valid drops and data holds.
        fetch(0, 32'h0000_0004);
        idle(0, 1);
        checkOutput("valid_drop", {31'd0, valid[0]}, 32'd0);
        checkOutput("instr_hold", instr[0], 32'h2222_2222);
        idle(0, 2);

        // Three wait states, request held high; address changes during WAIT.
        applyStimulus(2, 1'b1, 32'h0, 1'b0, 1'b0, 8'd0, 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(2, 1'b1, 32'h8, 1'b0, 1'b0, 8'd0, 32'd0);
        applyStimulus(2, 1'b1, 32'h8, 1'b0, 1'b0, 8'd0, 32'd0);
        idle(2, 6);

        // Faults: misaligned and out of range, both at one-edge latency.
        fetch(0, 32'h0000_0006);
        idle(0, 1);
        fetch(0, 32'h0000_0400);
        idle(0, 1);
        fetch(2, 32'h0000_0006);
        idle(2, 1);
        fetch(2, 32'h0000_0400);
        fetch(2, 32'hFFFF_FFFC);
        idle(2, 2);

        // Flush one cycle after acceptance drops the fetch.
        fetch(1, 32'h0000_0000);
        applyStimulus(1, 1'b0, 32'h0, 1'b1, 1'b0, 8'd0, 32'd0);
        vcount = 0;
        for (int i = 0; i < 5; i++) begin
            if (valid[1]) vcount++;
            idle(1, 1);
        end
        checkOutput("flush_no_valid", vcount, 0);
        // Flush together with a request: not accepted.
        applyStimulus(1, 1'b1, 32'h4, 1'b1, 1'b0, 8'd0, 32'd0);
        idle(1, 5);
        fetch(1, 32'h0000_000C);
        idle(1, 4);

        // Write and response read of the same word on the same edge.
        applyStimulus(0, 1'b1, 32'h4, 1'b0, 1'b1, 8'd1, 32'hDEAD_BEEF);
        fetch(0, 32'h0000_0004);
        idle(0, 2);

        // Asynchronous reset in the middle of WAIT.
        fetch(2, 32'h0000_0008);
        idle(2, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", {31'd0, valid[2]}, 32'd0);
        checkOutput("arst_fault", {31'd0, fault[2]}, 32'd0);
        checkOutput("arst_instr", instr[2], NOP);
        checkOutput("arst_ready", {31'd0, ready[2]}, 32'd1);
        sb.delete();
        for (int k = 0; k < 3; k++) busy[k] = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2, 5);
        fetch(2, 32'h0000_000C);
        idle(2, 6);

        checkOutput("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
